// File: rtl/prga_stream.sv
// RC4 keystream (PRGA) decryptor: streams a length-prefixed ciphertext from ct memory through the S box into pt memory.
// Optional build macro PRGA_EARLY_ABORT_EN: stop at the first out-of-range plaintext byte instead of finishing the message.
module prga_stream #(
  parameter int         LEN_BYTES = 1,
  parameter int         CT_AW     = 8,
  parameter logic [7:0] CHAR_LO   = 8'h20,
  parameter logic [7:0] CHAR_HI   = 8'h7E
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic             rdy,
  output logic             pt_ok,
  output logic             pt_bad,
  output logic [7:0]       s_addr,
  input  logic [7:0]       s_rddata,
  output logic [7:0]       s_wrdata,
  output logic             s_wren,
  output logic [CT_AW-1:0] ct_addr,
  input  logic [7:0]       ct_rddata,
  output logic [CT_AW-1:0] pt_addr,
  output logic [7:0]       pt_wrdata,
  output logic             pt_wren
);

  // Handshake: en is taken on a rising edge only while rdy=1; rdy drops on the
  // following cycle and en is ignored until rdy returns after DONE.
  typedef enum logic [3:0] {
    IDLE, LEN, RD_SI, RD_SJ, WR_SJ, WR_SI, RD_PAD, WR_PT, DONE
  } state_t;

  localparam int KW    = CT_AW + 1;
  localparam int MAX_L = (1 << CT_AW) - LEN_BYTES;
  localparam logic [CT_AW-1:0] PT_BASE = CT_AW'(LEN_BYTES - 1);

`ifdef PRGA_EARLY_ABORT_EN
  localparam bit EARLY_ABORT = 1'b1;
`else
  localparam bit EARLY_ABORT = 1'b0;
`endif

  state_t           state, state_d;
  logic [1:0]       cnt, cnt_d;
  logic             b, b_d;
  logic [15:0]      len_raw, len_raw_d;
  logic [KW-1:0]    len_q, len_q_d, k_q, k_d;
  logic [7:0]       i_q, i_d, j_q, j_d, si_q, si_d, sj_q, sj_d;
  logic             bad_q, bad_d;
  logic             rdy_d, pt_ok_d, pt_bad_d, s_wren_d, pt_wren_d;
  logic [7:0]       s_addr_d, s_wrdata_d, pt_wrdata_d;
  logic [CT_AW-1:0] ct_addr_d, pt_addr_d;

  logic             len_last, out_range, last_byte;
  logic [KW-1:0]    len_clamp;
  logic [7:0]       pad_byte;

  always_comb begin
    len_last  = (b == 1'(LEN_BYTES - 1));
    len_clamp = ({1'b0, len_raw} > 17'(MAX_L)) ? KW'(MAX_L) : len_raw[KW-1:0];
    pad_byte  = s_rddata ^ ct_rddata;
    out_range = (pad_byte < CHAR_LO) || (pad_byte > CHAR_HI);
    last_byte = (k_q == len_q) || (EARLY_ABORT && bad_q);
  end

  // State register and all registered outputs/datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      b         <= 1'b0;
      len_raw   <= '0;
      len_q     <= '0;
      k_q       <= '0;
      i_q       <= '0;
      j_q       <= '0;
      si_q      <= '0;
      sj_q      <= '0;
      bad_q     <= 1'b0;
      rdy       <= 1'b1;
      pt_ok     <= 1'b0;
      pt_bad    <= 1'b0;
      s_addr    <= '0;
      s_wrdata  <= '0;
      s_wren    <= 1'b0;
      ct_addr   <= '0;
      pt_addr   <= '0;
      pt_wrdata <= '0;
      pt_wren   <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      b         <= b_d;
      len_raw   <= len_raw_d;
      len_q     <= len_q_d;
      k_q       <= k_d;
      i_q       <= i_d;
      j_q       <= j_d;
      si_q      <= si_d;
      sj_q      <= sj_d;
      bad_q     <= bad_d;
      rdy       <= rdy_d;
      pt_ok     <= pt_ok_d;
      pt_bad    <= pt_bad_d;
      s_addr    <= s_addr_d;
      s_wrdata  <= s_wrdata_d;
      s_wren    <= s_wren_d;
      ct_addr   <= ct_addr_d;
      pt_addr   <= pt_addr_d;
      pt_wrdata <= pt_wrdata_d;
      pt_wren   <= pt_wren_d;
    end
  end

  // Next-state logic; two-cycle read states wait on cnt for the registered memory output
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (en && rdy) state_d = LEN;
      LEN:     if (cnt == 2'd2 && len_last) state_d = (len_clamp == '0) ? DONE : RD_SI;
      RD_SI:   if (cnt == 2'd1) state_d = RD_SJ;
      RD_SJ:   if (cnt == 2'd1) state_d = WR_SJ;
      WR_SJ:   state_d = WR_SI;
      WR_SI:   state_d = RD_PAD;
      RD_PAD:  if (cnt == 2'd1) state_d = WR_PT;
      WR_PT:   state_d = last_byte ? DONE : RD_SI;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of registered outputs and datapath
  always_comb begin
    cnt_d       = cnt;
    b_d         = b;
    len_raw_d   = len_raw;
    len_q_d     = len_q;
    k_d         = k_q;
    i_d         = i_q;
    j_d         = j_q;
    si_d        = si_q;
    sj_d        = sj_q;
    bad_d       = bad_q;
    rdy_d       = rdy;
    pt_ok_d     = pt_ok;
    pt_bad_d    = pt_bad;
    s_addr_d    = s_addr;
    s_wrdata_d  = s_wrdata;
    s_wren_d    = 1'b0;
    ct_addr_d   = ct_addr;
    pt_addr_d   = pt_addr;
    pt_wrdata_d = pt_wrdata;
    pt_wren_d   = 1'b0;
    case (state)
      IDLE: begin
        if (en && rdy) begin
          rdy_d     = 1'b0;
          pt_ok_d   = 1'b0;
          pt_bad_d  = 1'b0;
          bad_d     = 1'b0;
          cnt_d     = '0;
          b_d       = 1'b0;
          len_raw_d = '0;
          len_q_d   = '0;
          k_d       = '0;
          i_d       = '0;
          j_d       = '0;
          ct_addr_d = '0;
        end
      end
      LEN: begin
        cnt_d = cnt + 2'd1;
        if (cnt == 2'd1) begin
          if (b) len_raw_d[15:8] = ct_rddata;
          else   len_raw_d[7:0]  = ct_rddata;
          pt_addr_d   = ct_addr;
          pt_wrdata_d = ct_rddata;
          pt_wren_d   = 1'b1;
        end else if (cnt == 2'd2) begin
          cnt_d = '0;
          if (!len_last) begin
            b_d       = 1'b1;
            ct_addr_d = ct_addr + 1'b1;
          end else begin
            len_q_d  = len_clamp;
            k_d      = KW'(1);
            i_d      = 8'd1;
            s_addr_d = 8'd1;
          end
        end
      end
      RD_SI: begin
        cnt_d = cnt + 2'd1;
        if (cnt == 2'd1) begin
          cnt_d    = '0;
          si_d     = s_rddata;
          j_d      = j_q + s_rddata;
          s_addr_d = j_q + s_rddata;
        end
      end
      RD_SJ: begin
        cnt_d = cnt + 2'd1;
        if (cnt == 2'd1) begin
          cnt_d      = '0;
          sj_d       = s_rddata;
          s_addr_d   = j_q;
          s_wrdata_d = si_q;
          s_wren_d   = 1'b1;
        end
      end
      WR_SJ: begin
        // When i==j this rewrites the same value twice, leaving s[i] intact
        s_addr_d   = i_q;
        s_wrdata_d = sj_q;
        s_wren_d   = 1'b1;
      end
      WR_SI: begin
        s_addr_d  = si_q + sj_q;
        ct_addr_d = PT_BASE + k_q[CT_AW-1:0];
      end
      RD_PAD: begin
        cnt_d = cnt + 2'd1;
        if (cnt == 2'd1) begin
          cnt_d       = '0;
          pt_addr_d   = ct_addr;
          pt_wrdata_d = pad_byte;
          pt_wren_d   = 1'b1;
          if (out_range) bad_d = 1'b1;
        end
      end
      WR_PT: begin
        if (!last_byte) begin
          k_d      = k_q + 1'b1;
          i_d      = i_q + 8'd1;
          s_addr_d = i_q + 8'd1;
        end
      end
      DONE: begin
        pt_ok_d  = !bad_q;
        pt_bad_d = bad_q;
        rdy_d    = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/prga_stream.md
PRGA_STREAM -- requirements
Module: prga_stream

Interface
REQ-001 Parameter LEN_BYTES, 1, width of the little-endian length prefix in ct memory in bytes (1 or 2).
REQ-002 Parameter CT_AW, 8, address width of the ct and pt memories.
REQ-003 Parameter CHAR_LO, 8'h20, lowest acceptable plaintext byte.
REQ-004 Parameter CHAR_HI, 8'h7E, highest acceptable plaintext byte.
REQ-005 Ports, in order:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  asynchronous active-high reset.
- en  in  1  start request.
- rdy  out  1  idle, accepting en.
- pt_ok  out  1  last run completed, all bytes in range.
- pt_bad  out  1  last run saw an out-of-range byte.
- s_addr  out  8  S memory address.
- s_rddata  in  8  S memory read data.
- s_wrdata  out  8  S memory write data.
- s_wren  out  1  S memory write enable.
- ct_addr  out  CT_AW  ct memory address (read only).
- ct_rddata  in  8  ct read data.
- pt_addr  out  CT_AW  pt memory address.
- pt_wrdata  out  8  pt write data.
- pt_wren  out  1  pt write enable.

Function
REQ-006 All outputs SHALL be registered; memories are single-port with registered output, and read data SHALL be sampled on the second rising edge after the address register changes.
REQ-007 Handshake: en SHALL be sampled only while rdy=1; rdy SHALL drop on the next cycle; en while rdy=0 SHALL be ignored.
REQ-008 States SHALL be IDLE, LEN, RD_SI, RD_SJ, WR_SJ, WR_SI, RD_PAD, WR_PT, DONE.
REQ-009 LEN SHALL read ct[0..LEN_BYTES-1] into length L (little-endian) and copy those bytes unchanged to pt[0..LEN_BYTES-1].
REQ-010 L SHALL be clamped to 2^CT_AW - LEN_BYTES; L=0 SHALL go directly to DONE with pt_ok=1.
REQ-011 Per byte k (1..L): i=(i+1) mod 256; RD_SI (2 cycles) reads s[i]; j=(j+s[i]) mod 256; RD_SJ (2) reads s[j]; WR_SJ (1) writes s[j]=s[i]; WR_SI (1) writes s[i]=old s[j]; RD_PAD (2) reads s[(s[i]+s[j]) mod 256] and ct[LEN_BYTES-1+k] in parallel; WR_PT (1) writes pt[LEN_BYTES-1+k]=pad xor ct.
REQ-012 Throughput SHALL be exactly 9 cycles per byte; i,j SHALL start at 0 each run.
REQ-013 When i=j, the two writes SHALL leave s[i] unchanged.
REQ-014 Each written byte outside [CHAR_LO,CHAR_HI] SHALL set a sticky bad flag for the run.
REQ-015 DONE (1 cycle) SHALL set pt_ok=!bad, pt_bad=bad, then IDLE with rdy=1; flags SHALL hold until the next accepted en, which clears both.
REQ-016 s_wren and pt_wren SHALL be 1 only in WR_SJ/WR_SI and LEN/WR_PT respectively, for one cycle per write.

Reset
REQ-017 Reset SHALL set state IDLE, rdy=1, pt_ok=0, pt_bad=0, all addresses, wrdata, wren, i, j, k, L to 0, independent of clk.
REQ-018 Reset mid-run SHALL abort immediately with no further memory writes; partial pt contents are undefined.

Configuration
REQ-019 Macro PRGA_EARLY_ABORT_EN defined: after the first out-of-range byte is written, the block SHALL go to DONE with pt_bad=1, skipping remaining bytes.
REQ-020 Macro PRGA_EARLY_ABORT_EN undefined: all L bytes SHALL always be processed; pt_bad reports the sticky flag.

Verification
REQ-021 S preloaded with KSA of key 0x4B6579, LEN_BYTES=1, ct=09 BB F3 16 E8 D9 40 AF 0A D3 -> pt=09 "Plaintext", pt_ok=1, pt_bad=0, rdy back after 9*9 + LEN + DONE cycles.
REQ-022 ct[0]=00 -> pt[0]=00, no s_wren pulse, pt_ok=1.
REQ-023 LEN_BYTES=2, CT_AW=10, ct[0..1]=2C 01 (L=300) -> 300 bytes written, i wraps past 255, output matches software RC4 model.
REQ-024 Pad producing byte 0x07 at k=3 of 9: with PRGA_EARLY_ABORT_EN only pt[1..3] written and pt_bad=1; without, all 9 written and pt_bad=1.
REQ-025 Assert rst at byte 5 of a run -> next cycle rdy=1, all wren=0, flags 0; en during busy -> ignored.
